// File: rtl/ctrl_riesgos_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package : riesgos_pkg                                                      |
// | Purpose : Shared definitions for the ctrl_riesgos hazard sequencer:        |
// |           FSM state encoding, decoder polarity constants and the zero      |
// |           register index.                                                  |
// | Ports   : none (package).                                                  |
// | Options : CTRL_RIESGOS_STATS_EN is consumed by ctrl_riesgos, not here.     |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
package riesgos_pkg;

   // Raw encoding is visible on the estado debug port, so values are fixed.
   typedef enum logic [1:0] {
      INICIO     = 2'b00,
      NORMAL     = 2'b01,
      ESPERA_MEM = 2'b10,
      ERROR      = 2'b11
   } estado_t;

   // Decoder control bits (REG_RD, MEM_RD, resetIF) are active-low.
   localparam logic ACTIVO    = 1'b0;
   localparam logic DESACTIVO = 1'b1;

   // $zero can never carry a real dependency.
   localparam logic [4:0] REG_CERO = 5'd0;

endpackage : riesgos_pkg
`default_nettype wire

// File: rtl/ctrl_riesgos_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface : ctrl_riesgos_if                                                |
// | Purpose   : Bundles the decode/EX/MEM observation signals and the pipeline |
// |             control outputs of ctrl_riesgos.                               |
// | Modports  : slave  - the sequencer (observes pipeline, drives controls)    |
// |             master - the pipeline side (drives observations)               |
// | Signals   : id_rs, id_rt, id_reg_rd_n, id_usa_rt, id_salto_n, ex_mem_rd_n, |
// |             ex_rt, mem_acceso, mem_listo -> sequencer                      |
// |             pc_en, ifid_en, ifid_flush, idex_en, idex_burbuja, exmem_en,   |
// |             memwb_burbuja, err_timeout, estado[1:0] <- sequencer           |
// | Rev       : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
interface ctrl_riesgos_if;
   logic [4:0] id_rs;
   logic [4:0] id_rt;
   logic       id_reg_rd_n;
   logic       id_usa_rt;
   logic       id_salto_n;
   logic       ex_mem_rd_n;
   logic [4:0] ex_rt;
   logic       mem_acceso;
   logic       mem_listo;

   logic       pc_en;
   logic       ifid_en;
   logic       ifid_flush;
   logic       idex_en;
   logic       idex_burbuja;
   logic       exmem_en;
   logic       memwb_burbuja;
   logic       err_timeout;
   logic [1:0] estado;

   modport slave (
      input  id_rs, id_rt, id_reg_rd_n, id_usa_rt, id_salto_n,
             ex_mem_rd_n, ex_rt, mem_acceso, mem_listo,
      output pc_en, ifid_en, ifid_flush, idex_en, idex_burbuja,
             exmem_en, memwb_burbuja, err_timeout, estado
   );

   modport master (
      output id_rs, id_rt, id_reg_rd_n, id_usa_rt, id_salto_n,
             ex_mem_rd_n, ex_rt, mem_acceso, mem_listo,
      input  pc_en, ifid_en, ifid_flush, idex_en, idex_burbuja,
             exmem_en, memwb_burbuja, err_timeout, estado
   );
endinterface : ctrl_riesgos_if
`default_nettype wire

// File: rtl/ctrl_riesgos_detector_carga_uso.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : detector_carga_uso                                               |
// | Purpose : Combinational load-use detector. Flags when the load in EX       |
// |           writes a register the instruction in ID is about to read.       |
// | Ports   : id_rs[4:0], id_rt[4:0]  in  source fields of the ID instruction  |
// |           id_reg_rd_n             in  0 = ID reads rs                      |
// |           id_usa_rt               in  1 = ID reads rt                      |
// |           ex_mem_rd_n             in  0 = EX instruction is a load         |
// |           ex_rt[4:0]              in  load destination                     |
// |           carga_uso               out 1 = stall required                   |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module detector_carga_uso
   import riesgos_pkg::*;
(
   input  wire logic [4:0] id_rs,
   input  wire logic [4:0] id_rt,
   input  wire logic       id_reg_rd_n,
   input  wire logic       id_usa_rt,
   input  wire logic       ex_mem_rd_n,
   input  wire logic [4:0] ex_rt,
   output logic            carga_uso
);

   logic w_usa_rs;
   logic w_usa_rt;

   assign w_usa_rs  = (id_reg_rd_n == ACTIVO) && (id_rs == ex_rt);
   assign w_usa_rt  = id_usa_rt && (id_rt == ex_rt);
   assign carga_uso = (ex_mem_rd_n == ACTIVO) && (ex_rt != REG_CERO) &&
                      (w_usa_rs || w_usa_rt);

endmodule : detector_carga_uso
`default_nettype wire

// File: rtl/ctrl_riesgos.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : ctrl_riesgos                                                     |
// | Purpose : Hazard/stall sequencer for the 5-stage MIPS pipeline: post-reset |
// |           warm-up, load-use stalls, jump flushes and multi-cycle memory    |
// |           waits with a sticky timeout error.                               |
// | Ports   : clk        in  rising-edge clock                                 |
// |           rst_n      in  asynchronous active-low reset                     |
// |           bus        ctrl_riesgos_if.slave (pipeline observations/controls)|
// |           stall_cnt  out [15:0] saturating stall counter (option only)     |
// | Options : CTRL_RIESGOS_STATS_EN adds the stall_cnt port and counter.       |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module ctrl_riesgos
   import riesgos_pkg::*;
#(
   parameter int ARRANQUE    = 2,
   parameter int TIMEOUT_MAX = 8,
   parameter int CNT_W       = 4
) (
   input  wire logic        clk,
   input  wire logic        rst_n,
   ctrl_riesgos_if.slave    bus
`ifdef CTRL_RIESGOS_STATS_EN
   ,
   output logic [15:0]      stall_cnt
`endif
);

   localparam logic [CNT_W-1:0] c_arr_fin = CNT_W'(ARRANQUE - 1);
   localparam logic [CNT_W-1:0] c_to_fin  = CNT_W'(TIMEOUT_MAX - 1);

   estado_t          state_q, state_d;
   logic [CNT_W-1:0] cnt_q,   cnt_d;
   logic             err_q,   err_d;

   logic w_carga_uso;
   logic w_inicio;   // warm-up output set
   logic w_stall;    // memory-stall output set
   logic w_pc_en, w_ifid_en, w_ifid_flush, w_idex_en;
   logic w_idex_burbuja, w_exmem_en, w_memwb_burbuja;

   detector_carga_uso u_detector (
      .id_rs       (bus.id_rs),
      .id_rt       (bus.id_rt),
      .id_reg_rd_n (bus.id_reg_rd_n),
      .id_usa_rt   (bus.id_usa_rt),
      .ex_mem_rd_n (bus.ex_mem_rd_n),
      .ex_rt       (bus.ex_rt),
      .carga_uso   (w_carga_uso)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= INICIO;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      err_d    = err_q;
      w_inicio = 1'b0;
      w_stall  = 1'b0;

      case (state_q)
         INICIO: begin
            w_inicio = 1'b1;
            if (cnt_q == c_arr_fin) begin
               state_d = NORMAL;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         NORMAL: begin
            if (bus.mem_acceso && !bus.mem_listo) begin
               w_stall = 1'b1;
               state_d = ESPERA_MEM;
               cnt_d   = CNT_W'(1);
            end
         end
         ESPERA_MEM: begin
            // Dropping mem_acceso mid-wait releases the stall like mem_listo.
            if (bus.mem_listo || !bus.mem_acceso) begin
               state_d = NORMAL;
               cnt_d   = '0;
            end else begin
               w_stall = 1'b1;
               if (cnt_q == c_to_fin) begin
                  state_d = ERROR;
                  err_d   = 1'b1;   // visible from the first ERROR cycle
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         default: begin   // ERROR: frozen until reset
            w_stall = 1'b1;
         end
      endcase
   end

   always_comb begin
      w_pc_en         = 1'b1;
      w_ifid_en       = 1'b1;
      w_ifid_flush    = 1'b0;
      w_idex_en       = 1'b1;
      w_idex_burbuja  = 1'b0;
      w_exmem_en      = 1'b1;
      w_memwb_burbuja = 1'b0;

      if (w_inicio) begin
         w_pc_en         = 1'b0;
         w_ifid_flush    = 1'b1;
         w_idex_burbuja  = 1'b1;
         w_memwb_burbuja = 1'b1;
      end else if (w_stall) begin
         w_pc_en         = 1'b0;
         w_ifid_en       = 1'b0;
         w_idex_en       = 1'b0;
         w_exmem_en      = 1'b0;
         w_memwb_burbuja = 1'b1;
      end else if (w_carga_uso) begin
         // Takes precedence over a jump; the jump is seen again next cycle.
         w_pc_en        = 1'b0;
         w_ifid_en      = 1'b0;
         w_idex_burbuja = 1'b1;
      end else if (bus.id_salto_n == ACTIVO) begin
         w_ifid_flush = 1'b1;
      end
   end

   assign bus.pc_en         = w_pc_en;
   assign bus.ifid_en       = w_ifid_en;
   assign bus.ifid_flush    = w_ifid_flush;
   assign bus.idex_en       = w_idex_en;
   assign bus.idex_burbuja  = w_idex_burbuja;
   assign bus.exmem_en      = w_exmem_en;
   assign bus.memwb_burbuja = w_memwb_burbuja;
   assign bus.err_timeout   = err_q;
   assign bus.estado        = state_q;

`ifdef CTRL_RIESGOS_STATS_EN
   logic [15:0] stall_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_q <= '0;
      end else if (!w_pc_en && (state_q == NORMAL || state_q == ESPERA_MEM)
                   && (stall_q != 16'hFFFF)) begin
         stall_q <= stall_q + 16'd1;
      end
   end

   assign stall_cnt = stall_q;
`endif

endmodule : ctrl_riesgos
`default_nettype wire
